// File: rtl/column_frame_buffer_if.sv
// ---------------------------------------------------------------------------
// column_frame_buffer_if
//   Avalon-MM register bus used to load column records into the frame
//   buffer and to read its status registers.
//
//   chipselect  master->slave  register access select
//   write       master->slave  write strobe
//   read        master->slave  read strobe
//   address     master->slave  4-bit register index
//   writedata   master->slave  16-bit write data
//   readdata    slave->master  16-bit registered read data (next cycle)
// ---------------------------------------------------------------------------
interface column_frame_buffer_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [3:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output chipselect,
    output write,
    output read,
    output address,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  write,
    input  read,
    input  address,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/column_frame_buffer.sv
// ---------------------------------------------------------------------------
// column_frame_buffer
//   NBUF-deep rotating column store. Software streams COLS records of WORDS
//   16-bit words into the back buffer over the register bus; the pixel
//   pipeline reads whole records from the front buffer with a fixed two-cycle
//   latency. A completed back buffer becomes "pending" and is promoted to the
//   front only on swap_strobe (vblank). Completing a frame while one is
//   already pending drops the older one and bumps a saturating counter.
//
//   clk          system clock
//   reset        synchronous, active-high
//   bus          register bus (slave modport)
//                  wr addr 0 : restart frame (wcol=0, stage=0)
//                  wr addr 1 : next data word
//                  rd addr 0 : {14'b0, write_busy, frame_ready}
//                  rd addr 1 : drop count
//                  rd addr 2 : write column
//                  rd addr 3 : staging word index
//   swap_strobe  vblank pulse; promotes the pending buffer to the front
//   rd_col       column requested by the pixel pipeline
//   rd_data      record for rd_col (word 0 in bits [15:0]), 2 cycles later
//   rd_valid     rd_data is meaningful
//   frame_ready  a completed back buffer is pending
// ---------------------------------------------------------------------------
module column_frame_buffer #(
  parameter  int COLS  = 640,
  parameter  int WORDS = 5,
  parameter  int NBUF  = 3,
  localparam int COL_W = $clog2(COLS),
  localparam int REC_W = 16 * WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  column_frame_buffer_if.slave bus,
  input  logic                 swap_strobe,
  input  logic [COL_W-1:0]     rd_col,
  output logic [REC_W-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 frame_ready
);

  localparam int BUF_W    = $clog2(NBUF);
  localparam int STG_W    = $clog2(WORDS);
  localparam int STG_BITS = 16 * (WORDS - 1);

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(WORDS - 1);
  localparam logic [COL_W:0]   COLS_X     = (COL_W + 1)'(COLS);

  // Column storage, one record per column per buffer. Never reset.
  logic [REC_W-1:0] mem [NBUF][COLS];

  // Buffer rotation / write-side control
  logic [BUF_W-1:0] rbuf_q, rbuf_d;
  logic [BUF_W-1:0] wbuf_q, wbuf_d;
  logic [BUF_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             frame_ready_q, frame_ready_d;
  logic [COL_W-1:0] wcol_q, wcol_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [15:0]      readdata_q, readdata_d;

  // Words of the record currently being assembled (the last word is never
  // staged: it arrives in the commit cycle and goes straight to memory).
  logic [STG_BITS-1:0] stg_q, stg_d;

  // Display read pipeline
  logic [COL_W-1:0] rd_col_p0_q;
  logic [BUF_W-1:0] rbuf_p0_q;
  logic             vld_p0_q;
  logic [REC_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;

  logic             wr_cyc;
  logic             commit;
  logic             complete;
  logic             swap;
  logic [REC_W-1:0] commit_rec;

  // Lowest buffer index that is neither a nor b.
  function automatic logic [BUF_W-1:0] pick_free(input logic [BUF_W-1:0] a,
                                                 input logic [BUF_W-1:0] b);
    logic [BUF_W-1:0] sel;
    sel = '0;
    for (int i = NBUF - 1; i >= 0; i--) begin
      if (BUF_W'(i) != a && BUF_W'(i) != b) sel = BUF_W'(i);
    end
    return sel;
  endfunction

  always_comb begin
    rbuf_d        = rbuf_q;
    wbuf_d        = wbuf_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    frame_ready_d = frame_ready_q;
    wcol_d        = wcol_q;
    stage_d       = stage_q;
    drop_cnt_d    = drop_cnt_q;
    stg_d         = stg_q;
    readdata_d    = readdata_q;

    wr_cyc     = bus.chipselect && bus.write;
    commit     = wr_cyc && (bus.address == 4'd1) && (stage_q == LAST_STAGE) && !reset;
    complete   = commit && (wcol_q == LAST_COL);
    swap       = swap_strobe && pend_vld_q;
    commit_rec = {bus.writedata, stg_q};

    if (wr_cyc && bus.address == 4'd0) begin
      wcol_d  = '0;
      stage_d = '0;
    end

    if (wr_cyc && bus.address == 4'd1) begin
      if (stage_q == LAST_STAGE) begin
        stage_d = '0;
      end else begin
        stage_d = stage_q + 1'b1;
        for (int i = 0; i < WORDS - 1; i++) begin
          if (stage_q == STG_W'(i)) stg_d[16*i +: 16] = bus.writedata;
        end
      end
    end

    if (commit) wcol_d = complete ? '0 : wcol_q + 1'b1;

    // Swap acts on pre-cycle state; a frame completing in the same cycle
    // then lands in the slot the swap just emptied, so it is not a drop.
    if (swap) begin
      rbuf_d        = pend_q;
      pend_vld_d    = 1'b0;
      frame_ready_d = 1'b0;
    end

    if (complete) begin
      if (pend_vld_q && !swap && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      pend_d        = wbuf_q;
      pend_vld_d    = 1'b1;
      frame_ready_d = 1'b1;
      wbuf_d        = pick_free(rbuf_d, wbuf_q);
    end

    if (bus.chipselect && bus.read) begin
      case (bus.address)
        4'd0:    readdata_d = {14'b0, (wcol_q != '0 || stage_q != '0), frame_ready_q};
        4'd1:    readdata_d = drop_cnt_q;
        4'd2:    readdata_d = 16'(wcol_q);
        4'd3:    readdata_d = 16'(stage_q);
        default: readdata_d = 16'h0000;
      endcase
    end

    rd_data_d = '0;
    if ({1'b0, rd_col_p0_q} < COLS_X) rd_data_d = mem[rbuf_p0_q][rd_col_p0_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf_q        <= '0;
      wbuf_q        <= BUF_W'(1);
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      wcol_q        <= '0;
      stage_q       <= '0;
      drop_cnt_q    <= '0;
      readdata_q    <= '0;
      rbuf_p0_q     <= '0;
      vld_p0_q      <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      rbuf_q        <= rbuf_d;
      wbuf_q        <= wbuf_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      frame_ready_q <= frame_ready_d;
      wcol_q        <= wcol_d;
      stage_q       <= stage_d;
      drop_cnt_q    <= drop_cnt_d;
      readdata_q    <= readdata_d;
      // Stage p0: capture request and the front buffer it addresses
      rbuf_p0_q     <= rbuf_q;
      vld_p0_q      <= 1'b1;
      // Stage p1: memory read into the output register
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= vld_p0_q;
    end
  end

  always_ff @(posedge clk) begin
    stg_q       <= stg_d;
    rd_col_p0_q <= rd_col;
    if (commit) mem[wbuf_q][wcol_q] <= commit_rec;
  end

  assign bus.readdata = readdata_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign frame_ready  = frame_ready_q;

endmodule

// File: tb/tb_column_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_column_frame_buffer
//   Directed table/sequences for the documented scenarios, then randomized
//   bus/swap/read traffic against a frame-level reference model (displayed,
//   pending and in-progress frames as plain arrays, staging as a queue).
// ---------------------------------------------------------------------------
module tb_column_frame_buffer;
  localparam int COLS  = 4;
  localparam int WORDS = 3;
  localparam int NBUF  = 3;
  localparam int COL_W = 2;
  localparam int REC_W = 48;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             swap_strobe = 1'b0;
  logic [COL_W-1:0] rd_col = '0;
  logic [REC_W-1:0] rd_data;
  logic             rd_valid;
  logic             frame_ready;

  column_frame_buffer_if bus();

  column_frame_buffer #(.COLS(COLS), .WORDS(WORDS), .NBUF(NBUF)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .swap_strobe (swap_strobe),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    bit          wr;
    bit          rd;
    bit          swap;
    logic [3:0]  addr;
    logic [15:0] data;
    bit          chk_en;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  // Reference model: frame-level view
  logic [REC_W-1:0] disp  [COLS];
  logic [REC_W-1:0] pendf [COLS];
  logic [REC_W-1:0] cur   [COLS];
  bit               disp_known;
  bit               pend_v;
  int               m_wcol;
  logic [15:0]      stg[$];
  int               m_drop;
  int               vcnt;
  bit               pipe_known;
  logic [REC_W-1:0] pipe_val;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_reg(input logic [3:0] a);
    case (a)
      4'd0:    return {14'b0, (m_wcol != 0 || stg.size() != 0), pend_v};
      4'd1:    return 16'(m_drop);
      4'd2:    return 16'(m_wcol);
      4'd3:    return 16'(stg.size());
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge(input bit wr, input logic [3:0] addr,
                            input logic [15:0] data, input bit swap);
    logic [REC_W-1:0] rec;
    if (swap && pend_v) begin
      disp       = pendf;
      disp_known = 1'b1;
      pend_v     = 1'b0;
    end
    if (wr && addr == 4'd0) begin
      m_wcol = 0;
      stg.delete();
    end else if (wr && addr == 4'd1) begin
      stg.push_back(data);
      if (stg.size() == WORDS) begin
        rec = '0;
        for (int k = 0; k < WORDS; k++) rec[16*k +: 16] = stg[k];
        cur[m_wcol] = rec;
        stg.delete();
        if (m_wcol == COLS - 1) begin
          if (pend_v && m_drop < 65535) m_drop++;
          pendf  = cur;
          pend_v = 1'b1;
          m_wcol = 0;
        end else begin
          m_wcol++;
        end
      end
    end
  endtask

  task automatic step(input bit wr, input bit rd, input logic [3:0] addr,
                      input logic [15:0] data, input bit swap,
                      input logic [COL_W-1:0] col);
    bit               nk;
    logic [REC_W-1:0] nv;
    logic [15:0]      er;
    bus.chipselect = wr || rd;
    bus.write      = wr;
    bus.read       = rd;
    bus.address    = addr;
    bus.writedata  = data;
    swap_strobe    = swap;
    rd_col         = col;
    nk = disp_known;
    nv = disp[col];
    er = model_reg(addr);
    @(posedge clk);
    model_edge(wr, addr, data, swap);
    vcnt++;
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(vcnt >= 2));
    chk("frame_ready", 64'(frame_ready), 64'(pend_v));
    if (rd) chk("readdata_model", 64'(bus.readdata), 64'(er));
    if (pipe_known && vcnt >= 2) chk("rd_data_model", 64'(rd_data), 64'(pipe_val));
    pipe_known     = nk;
    pipe_val       = nv;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    swap_strobe    = 1'b0;
  endtask

  task automatic wr1(input logic [15:0] data, input bit swap);
    step(1'b1, 1'b0, 4'd1, data, swap, 2'd0);
  endtask

  task automatic rdreg(input logic [3:0] addr, input string nm, input logic [15:0] exp);
    step(1'b0, 1'b1, addr, 16'h0, 1'b0, 2'd0);
    chk(nm, 64'(bus.readdata), 64'(exp));
  endtask

  task automatic frame(input logic [15:0] base);
    for (int i = 0; i < COLS * WORDS; i++) wr1(base + 16'(i), 1'b0);
  endtask

  task automatic show_col(input logic [COL_W-1:0] col, input string nm,
                          input logic [REC_W-1:0] exp);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, col);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, col);
    chk(nm, 64'(rd_data), 64'(exp));
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 4'd0;
    bus.writedata  = 16'h0;
    swap_strobe    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    disp_known = 1'b0;
    pend_v     = 1'b0;
    m_wcol     = 0;
    stg.delete();
    m_drop     = 0;
    vcnt       = 0;
    pipe_known = 1'b0;
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_frame_ready", 64'(frame_ready), 64'd0);
    chk("reset_readdata", 64'(bus.readdata), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
  endtask

  // Front, back and pending buffers must stay distinct at all times.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      checks++;
      if (dut.rbuf_q == dut.wbuf_q ||
          (dut.pend_vld_q && (dut.pend_q == dut.rbuf_q || dut.pend_q == dut.wbuf_q))) begin
        failures++;
        $display("FAIL buf_distinct: rbuf=%0d wbuf=%0d pend=%0d pend_vld=%0d required distinct",
                 dut.rbuf_q, dut.wbuf_q, dut.pend_q, dut.pend_vld_q);
      end
    end
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   r;
    bit   sw;
    logic [1:0]  c;
    logic [15:0] d;

    do_reset();
    mon_en = 1'b1;

    tbl.push_back('{0, 1, 0, 4'd0, 16'h0, 1, 16'h0000, "rst_status"});
    tbl.push_back('{0, 1, 0, 4'd1, 16'h0, 1, 16'h0000, "rst_drop"});
    tbl.push_back('{0, 1, 0, 4'd2, 16'h0, 1, 16'h0000, "rst_wcol"});
    for (int i = 0; i < COLS * WORDS; i++)
      tbl.push_back('{1, 0, 0, 4'd1, 16'h0100 + 16'(i), 0, 16'h0, "wr"});
    tbl.push_back('{0, 1, 0, 4'd0, 16'h0, 1, 16'h0001, "status_ready"});
    tbl.push_back('{0, 0, 1, 4'd0, 16'h0, 0, 16'h0, "swap"});
    tbl.push_back('{0, 1, 0, 4'd0, 16'h0, 1, 16'h0000, "status_after_swap"});
    tbl.push_back('{1, 0, 0, 4'd5, 16'hFFFF, 0, 16'h0, "wr_ignored"});
    tbl.push_back('{0, 1, 0, 4'd3, 16'h0, 1, 16'h0000, "stage_after_ignored"});
    tbl.push_back('{0, 1, 0, 4'd7, 16'h0, 1, 16'h0000, "unmapped_read"});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.wr, v.rd, v.addr, v.data, v.swap, 2'd2);
      if (v.chk_en) chk(v.nm, 64'(bus.readdata), 64'(v.exp));
    end
    chk("swap_col2", 64'(rd_data), 64'(48'h0108_0107_0106));

    // Two frames with no swap: the first is dropped.
    frame(16'h0200);
    frame(16'h0300);
    rdreg(4'd1, "drop_cnt", 16'h0001);
    rdreg(4'd0, "status_pending", 16'h0001);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 2'd0);
    show_col(2'd0, "drop_second_frame", 48'h0302_0301_0300);

    // Partial record discarded by a restart.
    wr1(16'h0AAA, 1'b0);
    wr1(16'h0BBB, 1'b0);
    rdreg(4'd3, "stage_partial", 16'h0002);
    rdreg(4'd0, "busy_partial", 16'h0002);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 2'd0);
    rdreg(4'd3, "stage_after_abort", 16'h0000);
    frame(16'h0400);
    rdreg(4'd2, "wcol_wrap", 16'h0000);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 2'd0);
    show_col(2'd0, "abort_col0", 48'h0402_0401_0400);
    show_col(2'd3, "abort_col3", 48'h040B_040A_0409);

    // Frame completion coinciding with a swap.
    frame(16'h0500);
    for (int i = 0; i < COLS * WORDS - 1; i++) wr1(16'h0600 + 16'(i), 1'b0);
    wr1(16'h060B, 1'b1);
    rdreg(4'd0, "simul_ready", 16'h0001);
    rdreg(4'd1, "simul_drop", 16'h0001);
    show_col(2'd0, "simul_old_pend", 48'h0502_0501_0500);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 2'd0);
    show_col(2'd0, "simul_new_frame", 48'h0602_0601_0600);
    rdreg(4'd0, "simul_after_swap", 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      r  = $urandom_range(0, 99);
      sw = ($urandom_range(0, 39) == 0);
      c  = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      if (r < 70)      step(1'b1, 1'b0, 4'd1, d, sw, c);
      else if (r < 73) step(1'b1, 1'b0, 4'd0, d, sw, c);
      else if (r < 76) step(1'b1, 1'b0, 4'($urandom_range(4, 15)), d, sw, c);
      else             step(1'b0, 1'b1, 4'($urandom_range(0, 7)), d, sw, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/column_frame_buffer.md
Name: column_frame_buffer

Overview:
- Parametrised successor to the triple-buffered column store inside the ray-casting VGA peripheral.
- Accepts per-column records from the Avalon slave as COLS × WORDS 16-bit words into a back buffer.
- Serves fixed-latency column reads to the pixel pipeline from a front buffer, with NBUF-deep rotation.
- Swaps buffers only on a vblank strobe and tracks dropped frames for software.

Parameters:
- COLS, 640, columns per frame; COL_W = $clog2(COLS) is derived.
- WORDS, 5, 16-bit words per column record; REC_W = 16*WORDS.
- NBUF, 3, number of column buffers; legal range 3..4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  4  register index
- writedata  in  16  write data
- readdata  out  16  registered read data
- swap_strobe  in  1  one-cycle pulse from the VGA timing logic at vcount 523
- rd_col  in  COL_W  column index requested by the pixel pipeline
- rd_data  out  REC_W  record for rd_col; word 0 in bits [15:0]
- rd_valid  out  1  rd_data corresponds to the rd_col presented two cycles earlier
- frame_ready  out  1  a completed back buffer is pending

Behaviour:
- Reset (synchronous, active-high) sets: rbuf=0, wbuf=1, pend=none, frame_ready=0, wcol=0, stage=0, drop_cnt=0, rd_data=0, rd_valid=0, readdata=0. Buffer contents are not cleared.
- Invariant: rbuf, wbuf and pend (if any) are always distinct indices.
- Register writes (chipselect && write):
  - addr 0: wcol=0, stage=0; any partial record is discarded.
  - addr 1: data word. The word is stored to the staging slot `stage`, then stage++.
    - When stage==WORDS-1, the full record {this word, staging} is committed to buf[wbuf][wcol] in that cycle and stage=0.
    - The commit target is buf[wbuf] only; rbuf is never written.
  - Other addresses: ignored.
- Column advance and frame completion:
  - After a commit with wcol<COLS-1, wcol++.
  - After a commit with wcol==COLS-1, the frame is complete:
    - If pend==none: pend=wbuf, frame_ready=1.
    - If pend was set: the old pending frame is dropped, pend=wbuf, drop_cnt++ (saturating at 16'hFFFF).
    - wbuf becomes the lowest index not equal to rbuf or the new pend; wcol=0.
- Swap: on swap_strobe with pend set, rbuf=pend, pend=none, frame_ready=0. A swap_strobe with no pending frame has no effect.
- Simultaneous swap and frame completion in the same cycle:
  - The swap uses pre-cycle state: rbuf=old pend, if one existed.
  - The completed frame then becomes the new pend and frame_ready stays 1. No drop is counted.
  - wbuf is chosen against the post-swap rbuf.
- Display read path, latency 2:
  - Cycle 0: rd_col is registered.
  - Cycle 1: memory read of buf[rbuf].
  - Cycle 2: rd_data is registered and rd_valid=1.
  - rd_valid is 0 for the first two cycles after reset, then 1.
  - rd_col >= COLS returns 0.
  - A swap changes the source buffer for requests registered after the swap cycle.
- Register reads (chipselect && read), readdata valid the next cycle:
  - addr 0: {14'b0, write_busy (wcol!=0 || stage!=0), frame_ready}
  - addr 1: drop_cnt
  - addr 2: zero-extended wcol
  - addr 3: {13'b0, stage}
  - other addresses: 0
- Reset asserted mid-column or mid-frame aborts the write without affecting buffer contents.

Test Plan (bench overrides COLS=4, WORDS=3, NBUF=3):
- Reset, then read addr 0/1/2 -> 0, 0, 0; rd_valid=0 for 2 cycles, then 1.
- Write 12 words (0x0100+i) to addr 1 -> frame_ready=1. Pulse swap_strobe, then set rd_col=2 -> two cycles later rd_data={0x0108,0x0107,0x0106}; frame_ready=0.
- Write two full frames without a swap -> drop_cnt=1; after a swap, rd_col=0 returns the second frame's column 0.
- Write 2 words, then addr 0, then a full frame -> column 0 holds the new words only; addr 3 reads 0 after the addr 0 write.
- With pend set, complete a frame in the same cycle as swap_strobe -> rbuf=old pend, frame_ready stays 1, drop_cnt unchanged; a second strobe shows the new frame.
- Across 6 frame/swap cycles, the read buffer is never written and {rbuf, wbuf, pend} stay distinct (checked by assertion).
